// File: rtl/pm_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pm_fetch_queue_pkg
//  Description : Shared defaults, the prefetch FIFO entry layout and a width
//                helper for the program-memory fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package pm_fetch_queue_pkg;

    localparam int c_pm_def_aw    = 16;
    localparam int c_pm_def_iw    = 32;
    localparam int c_pm_def_depth = 4;

    // One buffered fetch: the instruction word together with its address
    typedef struct packed {
        logic [c_pm_def_aw-1:0] addr;
        logic [c_pm_def_iw-1:0] ins;
    } pm_entry_t;

    // Width needed to hold an occupancy value in the range 0..depth
    function automatic int pm_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : pm_fetch_queue_if
//  Description : Control, instruction-memory and decode-side signals of the
//                fetch queue. master = fetch queue, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pm_fetch_queue_if #(
    parameter int AW    = pm_fetch_queue_pkg::c_pm_def_aw,
    parameter int IW    = pm_fetch_queue_pkg::c_pm_def_iw,
    parameter int DEPTH = pm_fetch_queue_pkg::c_pm_def_depth
);
    localparam int c_cw = pm_fetch_queue_pkg::pm_count_width(DEPTH);

    // Redirect and flow control from the pipeline
    logic [AW-1:0]   jmp_loc;
    logic            pc_mux_sel;
    logic            stall;
    logic            stall_pm;

    // Instruction memory port
    logic            imem_req;
    logic [AW-1:0]   imem_addr;
    logic [IW-1:0]   imem_data;

    // Decode side
    logic [IW-1:0]   ins;
    logic [AW-1:0]   current_address;
    logic            ins_valid;
    logic [c_cw-1:0] fifo_count;

    modport master (
        input  jmp_loc, pc_mux_sel, stall, stall_pm, imem_data,
        output imem_req, imem_addr, ins, current_address, ins_valid, fifo_count
    );

    modport slave (
        output jmp_loc, pc_mux_sel, stall, stall_pm, imem_data,
        input  imem_req, imem_addr, ins, current_address, ins_valid, fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/pm_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pm_fetch_queue_fifo
//  Description : Register FIFO with push, pop, synchronous flush and count.
//                The head entry lives in its own register so the outputs are
//                purely registered and hold their last value when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_fetch_queue_fifo
    import pm_fetch_queue_pkg::*;
#(
    parameter int  DEPTH = c_pm_def_depth,
    parameter type T     = pm_entry_t
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_flush,
    input  logic                              i_push,
    input  T                                  i_push_data,
    input  logic                              i_pop,
    output T                                  o_head_data,
    output logic                              o_head_valid,
    output logic [pm_count_width(DEPTH)-1:0]  o_count
);

    localparam int c_cw = pm_count_width(DEPTH);
    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                r_mem [DEPTH];
    T                r_head;
    T                w_head_n;
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw-1:0] w_rd_next;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] w_count_n;
    logic            w_empty;
    logic            w_full;
    logic            w_pop_ok;
    logic            w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cw'(DEPTH));
    assign w_pop_ok  = i_pop && !w_empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign w_rd_next = r_rd_ptr + c_pw'(1);

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_n = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_n = r_count + c_cw'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_n = r_count - c_cw'(1);
        end
    end

    // Next head: the incoming word when it becomes the only entry, else the
    // successor after a pop; otherwise the head (possibly stale) is held
    always_comb begin
        w_head_n = r_head;
        if (w_push_ok && (w_empty || (w_pop_ok && r_count == c_cw'(1)))) begin
            w_head_n = i_push_data;
        end else if (w_pop_ok && r_count > c_cw'(1)) begin
            w_head_n = r_mem[w_rd_next];
        end
    end

    // Entry storage, no reset needed: occupancy decides which slots are live
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, count and head register; flush keeps the last head visible
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= w_count_n;
            r_head  <= w_head_n;
        end
    end

    // Upstream credit must never let the FIFO overflow
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && i_push) begin
            assert (!w_full || w_pop_ok);
        end
    end

    assign o_head_data  = r_head;
    assign o_head_valid = !w_empty;
    assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/pm_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pm_fetch_queue
//  Description : Program-memory fetch unit: PC generator, jump redirect,
//                credit-based fetch issue to a 1-cycle synchronous memory and
//                a prefetch FIFO feeding decode with a valid/stall handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_fetch_queue
    import pm_fetch_queue_pkg::*;
#(
    parameter int            AW         = c_pm_def_aw,
    parameter int            IW         = c_pm_def_iw,
    parameter int            DEPTH      = c_pm_def_depth,
    parameter logic [AW-1:0] RESET_ADDR = '0,
    parameter int            PC_STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    pm_fetch_queue_if.master bus
);

    localparam int c_cw = pm_count_width(DEPTH);
    localparam int c_ow = c_cw + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] ins;
    } entry_t;

    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_req_addr;
    logic            r_inflight;
    logic [c_cw-1:0] w_count;
    logic [c_ow-1:0] w_occupancy;
    logic            w_credit_ok;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_head_valid;
    entry_t          w_head;
    entry_t          w_push_data;

    // Buffered plus outstanding words; a same-cycle dequeue is not credited
    assign w_occupancy = {1'b0, w_count} + c_ow'(r_inflight);
    assign w_credit_ok = (w_occupancy < c_ow'(DEPTH));

    assign w_req = !reset && !bus.pc_mux_sel && !bus.stall_pm && w_credit_ok;

    // A response landing in a redirect cycle belongs to the old stream
    assign w_push      = r_inflight && !bus.pc_mux_sel;
    assign w_pop       = w_head_valid && !bus.stall;
    assign w_push_data = '{addr: r_req_addr, ins: bus.imem_data};

    // PC, outstanding-request flag and the address of that request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_ADDR;
            r_inflight <= 1'b0;
            r_req_addr <= '0;
        end else if (bus.pc_mux_sel) begin
            r_pc       <= bus.jmp_loc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc       <= r_pc + AW'(PC_STEP);
                r_req_addr <= r_pc;
            end
        end
    end

    pm_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_flush      (bus.pc_mux_sel),
        .i_push       (w_push),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_head_data  (w_head),
        .o_head_valid (w_head_valid),
        .o_count      (w_count)
    );

    assign bus.imem_req        = w_req;
    assign bus.imem_addr       = r_pc;
    assign bus.ins             = w_head.ins;
    assign bus.current_address = w_head.addr;
    assign bus.ins_valid       = w_head_valid;
    assign bus.fifo_count      = w_count;

endmodule
`default_nettype wire
